alu_div_seq: RTL and testbench
==============================

// Module: alu_div_seq
// PURPOSE
//  Multi-cycle integer divide sequencer beside the single-cycle EX-stage ALU. Holds operands,
//  runs a radix-2 restoring divide (one quotient bit per enabled cycle), stalls the pipeline
//  until the result is ready, and returns quotient, remainder and O|S|Z|C flags.
// PARAMETERS
//  WIDTH    32  operand/result width in bits
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      reset, synchronous, active-low; not gated by clk_en
//  clk_en       in   1      global clock enable; 0 freezes all state (flush included)
//  start        in   1      request a divide; sampled only in IDLE
//  signed_op    in   1      1 = signed (truncating) divide, 0 = unsigned
//  dividend     in   WIDTH  numerator, sampled with start
//  divisor      in   WIDTH  denominator, sampled with start
//  flush        in   1      abort in-flight op (pipeline bubble/redirect)
//  busy         out  1      state != IDLE
//  stall        out  1      busy & ~done; holds the pipeline front end
//  done         out  1      one-cycle pulse; result outputs valid from this cycle on
//  quotient     out  WIDTH  registered quotient
//  remainder    out  WIDTH  registered remainder
//  flags        out  4      {O,S,Z,C}, same ordering as the ALU flag register
// BEHAVIOUR
//  Reset: state=IDLE; busy, stall, done, quotient, remainder, flags all 0.
//  All transitions below require clk_en=1. With clk_en=0, state, counter and outputs hold;
//  a done pulse stays high until the next enabled edge.
//  FSM:
//   IDLE -> PREP when start=1. Latch operands and signed_op. Latch sign_q = sign(dvd)^sign(dvs)
//          and sign_r = sign(dvd) (sign terms are 0 when unsigned). Latch dvz = (divisor==0).
//   PREP -> ITER: convert operands to magnitudes (two's-complement negate if signed and
//          negative); rem_acc=0; cnt=0.
//   ITER:  each edge: shift {rem_acc,quo_acc} left 1. If shifted rem >= |divisor|, subtract it
//          and set quo LSB to 1. cnt++. Leave for FIX after WIDTH iterations (cnt==WIDTH-1 edge).
//   FIX  -> DONE: negate quotient if sign_q; negate remainder if sign_r; load result registers.
//   DONE -> IDLE: done=1 for exactly this one cycle. start is ignored in DONE.
//  Latency: start sampled at edge E0; done is high in the cycle after edge E0+WIDTH+2
//   (35 enabled cycles for WIDTH=32). Stalled (clk_en=0) cycles add latency 1:1.
//  start while busy is ignored; the operand inputs are don't-care after E0.
//  flush=1 in any non-IDLE state: next state IDLE, no done pulse, result registers keep their
//   old values. flush in IDLE is a no-op. If flush and start are both 1 in IDLE, flush wins
//   and the request is dropped.
//  rst_n=0 mid-operation returns the block to the reset state on that edge.
//  Special results are forced at the FIX/DONE load and do not depend on the iteration:
//   divisor==0 : quotient = all ones, remainder = dividend (as supplied), C=1.
//   signed op with dividend=MIN_INT and divisor=-1 : quotient = MIN_INT, remainder = 0, O=1.
//  Flags, loaded with the results: O = signed-overflow case above; S = quotient[WIDTH-1];
//   Z = (quotient==0); C = divide-by-zero. Remainder has the sign of the dividend.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: IDLE goes directly to DONE when start=1 and divisor==0, so done
//   is high in the cycle after E0, with the forced divide-by-zero results and flags.
//  DIV_ZERO_FAST_EN undefined: divide-by-zero runs the full PREP/ITER/FIX sequence (full
//   latency), with identical final values. In both builds, flush in the fast path has no effect
//   because that path never occupies a non-IDLE state other than DONE.
// TESTING
//  unsigned 100 / 7 -> q=14, r=2, flags=0000, done exactly 35 cycles after start, stall high in
//   every one of those cycles.
//  signed -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF, flags=0100; unsigned 0xFFFFFFFF / 1 ->
//   q=0xFFFFFFFF, r=0, flags=0100.
//  5 / 0, run under both macro settings -> q=0xFFFFFFFF, r=5, flags=0101; done after 1 cycle
//   (macro on) or 35 cycles (macro off).
//  signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, flags=1100; 0 / 9 -> q=0, r=0,
//   flags=0010.
//  start 100/7, flush at cycle 10 -> IDLE next cycle, no done, outputs keep the prior result;
//   then start 9/3 -> q=3, r=0 after 35 cycles.
//  clk_en low for 5 cycles mid-ITER -> same q/r, done at cycle 40; start asserted while busy is
//   ignored; rst_n low mid-op -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_div_seq.sv
// Multi-cycle radix-2 restoring divider beside the EX-stage ALU (signed/unsigned, O|S|Z|C flags).
// Optional macro DIV_ZERO_FAST_EN: a divide-by-zero request skips straight to DONE.
module alu_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       flags
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             signed_q, signed_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dvz_q, dvz_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             stall_q, stall_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] q_res, r_res;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    signed_d    = signed_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    dvz_d       = dvz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    flags_d     = flags_q;
    shifted     = {rem_q, quo_q[WIDTH-1]};
    diff        = shifted - {1'b0, dvs_q};
    ge          = (shifted >= {1'b0, dvs_q});
    q_res       = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
    r_res       = rem_neg_q ? (~rem_q + 1'b1) : rem_q;

    // Forced special cases override whatever the iteration produced.
    if (dvz_q) begin
      q_res = '1;
      r_res = dvd_q;
    end else if (ovf_q) begin
      q_res = MIN_INT;
      r_res = '0;
    end

    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            dvd_d     = dividend;
            dvs_d     = divisor;
            signed_d  = signed_op;
            quo_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rem_neg_d = signed_op & dividend[WIDTH-1];
            dvz_d     = (divisor == '0);
            ovf_d     = signed_op && (dividend == MIN_INT) && (divisor == '1);
            state_d   = S_PREP;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
              state_d     = S_DONE;
              quotient_d  = '1;
              remainder_d = dividend;
              flags_d     = 4'b0101;
            end
`endif
          end
        end
        S_PREP: begin
          quo_d   = (signed_q && dvd_q[WIDTH-1]) ? (~dvd_q + 1'b1) : dvd_q;
          dvs_d   = (signed_q && dvs_q[WIDTH-1]) ? (~dvs_q + 1'b1) : dvs_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
        S_ITER: begin
          rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_FIX;
        end
        S_FIX: begin
          quotient_d  = q_res;
          remainder_d = r_res;
          flags_d     = {ovf_q, q_res[WIDTH-1], (q_res == '0), dvz_q};
          state_d     = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    stall_d = busy_d & ~done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      signed_q    <= 1'b0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      dvz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      flags_q     <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      signed_q    <= signed_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      dvz_q       <= dvz_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      flags_q     <= flags_d;
    end
  end

  assign busy      = busy_q;
  assign stall     = stall_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: directed vector table, random ops against an arithmetic model, and
// hand-written flush / clock-enable / reset sequences. Honours DIV_ZERO_FAST_EN latency.
module tb_alu_div_seq;

  localparam int LAT = 35;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clk_en, start, signed_op, flush;
  logic [31:0] dividend, divisor;
  logic        busy, stall, done;
  logic [31:0] quotient, remainder;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  alu_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .quotient(quotient), .remainder(remainder), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic [3:0] f);
    bit o, c;
    o = 1'b0;
    c = 1'b0;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; c = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; o = 1'b1;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    f = {o, q[31], (q == 0), c};
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    return (FAST && b == 0) ? 1 : LAT;
  endfunction

  // Called just after a negedge; E0 is the following posedge. Returns at a negedge in IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        output int lat, output bit stall_ok);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk);
    lat = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
      end
      if (done) begin
        lat = c;
        break;
      end
      if (!(stall && busy)) stall_ok = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit sok;
    bit seen;
    logic [31:0] a, b, eq, er;
    logic [3:0] ef;
    bit s;

    vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         4'b0000};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0100};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         4'b0100};
    vecs[3] = '{32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         4'b0101};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         4'b1100};
    vecs[5] = '{32'd0,         32'd9,         1'b0, 32'd0,         32'd0,         4'b0010};
    vecs[6] = '{32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 4'b0101};
    vecs[7] = '{32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 4'b0100};
    vecs[8] = '{32'd100,       32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2,         4'b0100};
    vecs[9] = '{32'hFFFF_FFFF, 32'h10,        1'b0, 32'h0FFF_FFFF, 32'hF,         4'b0000};

    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; signed_op = 1'b0; flush = 1'b0;
    dividend = 0; divisor = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, sok);
      $display("vec %0d: %08h / %08h s=%0d -> q=%08h r=%08h f=%04b lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].s, quotient, remainder, flags, lat);
      chk($sformatf("vec%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].f));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].b)));
      chk($sformatf("vec%0d_stall", i), 32'(sok), 32'd1);
    end

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = -32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(a, b, s, eq, er, ef);
      run_op(a, b, s, lat, sok);
      $display("rnd %0d: %08h / %08h s=%0d -> q=%08h r=%08h f=%04b lat=%0d",
               i, a, b, s, quotient, remainder, flags, lat);
      chk("rnd_q", quotient, eq);
      chk("rnd_r", remainder, er);
      chk("rnd_flags", 32'(flags), 32'(ef));
      chk("rnd_lat", 32'(lat), 32'(exp_lat(b)));
    end

    // Flush mid-ITER: no done, prior result retained, then a clean follow-up op.
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, sok);
    dividend = 100; divisor = 7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    $display("flush: q=%08h r=%08h f=%04b activity=%0d", quotient, remainder, flags, seen);
    chk("flush_no_done", 32'(seen), 32'd0);
    chk("flush_keep_q", quotient, 32'hFFFF_FFFF);
    chk("flush_keep_r", remainder, 32'd0);
    chk("flush_keep_flags", 32'(flags), 32'b0100);
    run_op(32'd9, 32'd3, 1'b0, lat, sok);
    $display("after flush 9/3: q=%08h r=%08h lat=%0d", quotient, remainder, lat);
    chk("post_flush_q", quotient, 32'd3);
    chk("post_flush_r", remainder, 32'd0);
    chk("post_flush_lat", 32'(lat), 32'(LAT));

    // Flush and start together in IDLE: request dropped.
    dividend = 50; divisor = 5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_flush_start_busy2", 32'(busy), 32'd0);

    // clk_en low for 5 cycles mid-ITER, start pulsed while busy.
    dividend = 100; divisor = 7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) clk_en = 1'b0;
      if (c == 12) chk("freeze_busy", 32'(busy & stall), 32'd1);
      if (c == 15) clk_en = 1'b1;
      if (c == 20) begin start = 1'b1; dividend = 9; divisor = 3; end
      if (c == 25) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    $display("clk_en stall: q=%08h r=%08h lat=%0d", quotient, remainder, lat);
    chk("stall_lat", 32'(lat), 32'd40);
    chk("stall_q", quotient, 32'd14);
    chk("stall_r", remainder, 32'd2);
    clk_en = 1'b0;
    @(negedge clk);
    chk("done_hold1", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_hold2", 32'(done), 32'd1);
    clk_en = 1'b1;
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_start_ignored", 32'(busy), 32'd0);

    // Reset mid-operation, asserted while clk_en is also low.
    dividend = 100; divisor = 7; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 15) begin rst_n = 1'b0; clk_en = 1'b0; end
    end
    @(negedge clk);
    $display("mid-op reset: busy=%0d q=%08h r=%08h f=%04b", busy, quotient, remainder, flags);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1; clk_en = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
